// File: rtl/vjtag_bus_engine.sv
// Command-driven bus master: single/burst reads and writes, target reset
// control and per-beat request/response timeout.
module vjtag_bus_engine #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 4,
  parameter int ADDR_INC   = 1,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [7:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  wvalid,
  output logic                  rvalid,
  output logic [DATA_WIDTH-1:0] wdata,
  input  logic                  ready,
  input  logic                  rsp_valid,
  input  logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rst_n_out,
  output logic                  busy,
  output logic                  done,
  output logic                  err_timeout
);

  typedef enum logic [2:0] {
    S_IDLE, S_WDATA, S_REQ, S_RESP, S_RDOUT, S_DONE
  } state_e;

  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [7:0] OP_READ   = 8'h01;
  localparam logic [7:0] OP_WRITE  = 8'h02;
  localparam logic [7:0] OP_BREAD  = 8'h03;
  localparam logic [7:0] OP_BWRITE = 8'h04;
  localparam logic [7:0] OP_CLRERR = 8'h10;
  localparam logic [7:0] OP_RST_A  = 8'hFE;
  localparam logic [7:0] OP_RST_D  = 8'hFF;

  state_e                state_q;
  logic                  wr_q;
  logic [LEN_WIDTH-1:0]  cnt_q;
  logic [TW-1:0]         tmo_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  rst_out_q;
  logic                  err_q;

  logic                  last;
  logic                  tmo_hit;
  logic [ADDR_WIDTH-1:0] addr_nxt;

  assign last     = (cnt_q == '0);
  assign tmo_hit  = (tmo_q >= TW'(TIMEOUT - 1));
  assign addr_nxt = addr_q + ADDR_WIDTH'(ADDR_INC);

  assign cmd_ready   = (state_q == S_IDLE);
  assign wr_ready    = (state_q == S_WDATA);
  assign wvalid      = (state_q == S_REQ) && wr_q;
  assign rvalid      = (state_q == S_REQ) && !wr_q;
  assign rd_valid    = (state_q == S_RDOUT);
  assign done        = (state_q == S_DONE);
  assign busy        = (state_q != S_IDLE);
  assign address     = addr_q;
  assign wdata       = wdata_q;
  assign rd_data     = rdata_q;
  assign rst_n_out   = rst_out_q;
  assign err_timeout = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      wr_q      <= 1'b0;
      cnt_q     <= '0;
      tmo_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      rst_out_q <= 1'b1;
      err_q     <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            addr_q <= cmd_addr;
            tmo_q  <= '0;
            cnt_q  <= '0;
            case (cmd_op)
              OP_READ: begin
                wr_q    <= 1'b0;
                state_q <= S_REQ;
              end
              OP_WRITE: begin
                wr_q    <= 1'b1;
                state_q <= S_WDATA;
              end
              OP_BREAD: begin
                wr_q    <= 1'b0;
                cnt_q   <= cmd_len;
                state_q <= S_REQ;
              end
              OP_BWRITE: begin
                wr_q    <= 1'b1;
                cnt_q   <= cmd_len;
                state_q <= S_WDATA;
              end
              OP_CLRERR: begin
                err_q   <= 1'b0;
                state_q <= S_DONE;
              end
              OP_RST_A: begin
                rst_out_q <= 1'b0;
                state_q   <= S_DONE;
              end
              OP_RST_D: begin
                rst_out_q <= 1'b1;
                state_q   <= S_DONE;
              end
              default: state_q <= S_DONE;
            endcase
          end
        end
        S_WDATA: begin
          if (wr_valid) begin
            wdata_q <= wr_data;
            tmo_q   <= '0;
            state_q <= S_REQ;
          end
        end
        S_REQ: begin
          if (ready) begin
            if (!wr_q) begin
              // timer keeps running into RESP: one budget per beat
              tmo_q   <= tmo_q + TW'(1);
              state_q <= S_RESP;
            end else if (last) begin
              state_q <= S_DONE;
            end else begin
              cnt_q   <= cnt_q - LEN_WIDTH'(1);
              addr_q  <= addr_nxt;
              state_q <= S_WDATA;
            end
          end else if (tmo_hit) begin
            err_q   <= 1'b1;
            state_q <= S_DONE;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        S_RESP: begin
          if (rsp_valid) begin
            rdata_q <= rsp_data;
            state_q <= S_RDOUT;
          end else if (tmo_hit) begin
            err_q   <= 1'b1;
            state_q <= S_DONE;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        S_RDOUT: begin
          if (rd_ready) begin
            if (last) begin
              state_q <= S_DONE;
            end else begin
              cnt_q   <= cnt_q - LEN_WIDTH'(1);
              addr_q  <= addr_nxt;
              tmo_q   <= '0;
              state_q <= S_REQ;
            end
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vjtag_bus_engine.sv
// Directed bench for vjtag_bus_engine: single/burst transfers, timeout,
// target reset ops and asynchronous reset mid-burst.
module tb_vjtag_bus_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready;
  logic [7:0]  cmd_op;
  logic [15:0] cmd_addr;
  logic [3:0]  cmd_len;
  logic        wr_valid, wr_ready;
  logic [15:0] wr_data;
  logic        rd_valid, rd_ready;
  logic [15:0] rd_data;
  logic [15:0] address;
  logic        wvalid, rvalid;
  logic [15:0] wdata;
  logic        ready, rsp_valid;
  logic [15:0] rsp_data;
  logic        rst_n_out, busy, done, err_timeout;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  vjtag_bus_engine dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .address(address), .wvalid(wvalid), .rvalid(rvalid),
    .wdata(wdata), .ready(ready), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rst_n_out(rst_n_out), .busy(busy),
    .done(done), .err_timeout(err_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input int w);
    case (w)
      0:       return rvalid;
      1:       return wvalid;
      2:       return rd_valid;
      default: return done;
    endcase
  endfunction

  task automatic wait_sig(input int w, input string tag);
    int n = 0;
    while (!sig(w) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(sig(w)), 32'd1);
  endtask

  // Called at a negedge in IDLE; returns one negedge after acceptance.
  task automatic send(input logic [7:0] op, input logic [15:0] a,
                      input logic [3:0] len);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_len   = len;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  initial begin
    int cnt, hs, given, viol;
    bit seen_done;
    rst_n = 1'b0; cmd_valid = 0; cmd_op = 0; cmd_addr = 0; cmd_len = 0;
    wr_valid = 0; wr_data = 0; rd_ready = 0; ready = 0;
    rsp_valid = 0; rsp_data = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rstout", 32'(rst_n_out), 1);
    chk("rst_err", 32'(err_timeout), 0);
    chk("rst_addr", 32'(address), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_cmdrdy", 32'(cmd_ready), 1);

    // single WRITE
    ready = 1; wr_valid = 1; wr_data = 16'hBEEF;
    send(8'h02, 16'h0010, 4'd7);
    chk("wr_wready", 32'(wr_ready), 1);
    chk("wr_nowv", 32'(wvalid), 0);
    @(negedge clk);
    wr_valid = 0;
    chk("wr_wvalid", 32'(wvalid), 1);
    chk("wr_addr", 32'(address), 32'h0010);
    chk("wr_wdata", 32'(wdata), 32'hBEEF);
    @(negedge clk);
    chk("wr_wv_off", 32'(wvalid), 0);
    chk("wr_done", 32'(done), 1);
    @(negedge clk);
    chk("wr_done_off", 32'(done), 0);
    chk("wr_idle", 32'(busy), 0);

    // BREAD wrapping the address, with rd_ready stalls
    send(8'h03, 16'hFFFE, 4'd2);
    for (int i = 0; i < 3; i++) begin
      wait_sig(0, "br_rvalid");
      chk("br_addr", 32'(address), 32'((16'hFFFE + i) & 16'hFFFF));
      @(negedge clk);
      chk("br_resp_rv", 32'(rvalid), 0);
      rsp_valid = 1; rsp_data = 16'(16'hA + i);
      @(negedge clk);
      rsp_valid = 0;
      chk("br_rdv", 32'(rd_valid), 1);
      chk("br_rdata", 32'(rd_data), 32'(16'hA + i));
      @(negedge clk);
      chk("br_stall", 32'(rd_valid), 1);
      rd_ready = 1;
      @(negedge clk);
      rd_ready = 0;
    end
    chk("br_done", 32'(done), 1);
    @(negedge clk);

    // READ timeout, then CLR_ERR
    ready = 0;
    send(8'h01, 16'h0300, 4'd0);
    cnt = 0;
    while (rvalid && cnt < 300) begin
      cnt++;
      @(negedge clk);
    end
    chk("to_cycles", 32'(cnt), 255);
    chk("to_rv_off", 32'(rvalid), 0);
    chk("to_err", 32'(err_timeout), 1);
    chk("to_done", 32'(done), 1);
    @(negedge clk);
    chk("to_sticky", 32'(err_timeout), 1);
    send(8'h10, 16'h0, 4'd0);
    chk("clr_err", 32'(err_timeout), 0);
    chk("clr_done", 32'(done), 1);
    @(negedge clk);

    // BWRITE len 3 with wr_valid gaps and ready toggling
    send(8'h04, 16'h0100, 4'd3);
    hs = 0; given = 0; viol = 0; seen_done = 0;
    for (int c = 0; c < 200; c++) begin
      if (done) begin
        seen_done = 1;
        break;
      end
      if (wr_ready && wvalid) viol++;
      wr_valid = (c % 3 == 2);
      wr_data  = 16'(16'h1000 + given);
      ready    = (c % 2 == 1);
      if (wr_valid && wr_ready) given++;
      if (wvalid && ready) begin
        chk("bw_addr", 32'(address), 32'(16'h0100 + hs));
        chk("bw_wdata", 32'(wdata), 32'(16'h1000 + hs));
        hs++;
      end
      @(negedge clk);
    end
    wr_valid = 0; ready = 0;
    chk("bw_done", 32'(seen_done), 1);
    chk("bw_hs", 32'(hs), 4);
    chk("bw_viol", 32'(viol), 0);
    @(negedge clk);

    // target reset ops and unknown opcode
    send(8'hFE, 16'h0, 4'd0);
    chk("rsta_out", 32'(rst_n_out), 0);
    chk("rsta_bus", 32'({wvalid, rvalid}), 0);
    chk("rsta_done", 32'(done), 1);
    @(negedge clk);
    send(8'hFF, 16'h0, 4'd0);
    chk("rstd_out", 32'(rst_n_out), 1);
    @(negedge clk);
    send(8'h55, 16'h0, 4'd0);
    chk("nop_done", 32'(done), 1);
    chk("nop_bus", 32'({wvalid, rvalid, wr_ready, rd_valid}), 0);
    @(negedge clk);

    // async reset while in RESP
    ready = 1;
    send(8'h03, 16'h2000, 4'd3);
    @(negedge clk);
    chk("ar_resp", 32'({busy, rvalid}), 32'b10);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_busy", 32'(busy), 0);
    chk("ar_addr", 32'(address), 0);
    chk("ar_rdata", 32'(rd_data), 0);
    chk("ar_wdata", 32'(wdata), 0);
    chk("ar_outs", 32'({wvalid, rvalid, rd_valid, wr_ready, done}), 0);
    chk("ar_rstout", 32'(rst_n_out), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ar_cmdrdy", 32'(cmd_ready), 1);
    send(8'h01, 16'h0042, 4'd9);
    wait_sig(0, "pr_rvalid");
    chk("pr_addr", 32'(address), 32'h0042);
    @(negedge clk);
    rsp_valid = 1; rsp_data = 16'h5A5A;
    @(negedge clk);
    rsp_valid = 0;
    chk("pr_rdata", 32'(rd_data), 32'h5A5A);
    rd_ready = 1;
    @(negedge clk);
    rd_ready = 0;
    chk("pr_done", 32'(done), 1);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vjtag_bus_engine.md
VJTAG_BUS_ENGINE -- requirements
Module: vjtag_bus_engine

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, bus address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, bus data width.
REQ-003 SHALL have parameter LEN_WIDTH, default 4, burst-length field width (max burst 2^LEN_WIDTH beats).
REQ-004 SHALL have parameter ADDR_INC, default 1, address increment per burst beat.
REQ-005 SHALL have parameter TIMEOUT, default 255, max cycles waiting for ready or rsp_valid per beat.
REQ-006 SHALL use one clock and an asynchronous active-low reset: clk (in, 1, system clock) and rst_n (in, 1, async active-low reset).
REQ-007 SHALL have ports:
 cmd_valid in 1 command present (already in clk domain)
 cmd_ready out 1 engine accepts command
 cmd_op in 8 opcode
 cmd_addr in ADDR_WIDTH start address
 cmd_len in LEN_WIDTH beats minus 1
 wr_valid/wr_ready in/out 1 write-data stream handshake
 wr_data in DATA_WIDTH write beat
 rd_valid/rd_ready out/in 1 read-return handshake
 rd_data out DATA_WIDTH read beat
 address out ADDR_WIDTH bus address
 wvalid/rvalid out 1 bus write/read request
 wdata out DATA_WIDTH bus write data
 ready in 1 bus accepts request
 rsp_valid in 1 read response valid
 rsp_data in DATA_WIDTH read response data
 rst_n_out out 1 target reset
 busy out 1 state != IDLE
 done out 1 one-cycle completion pulse
 err_timeout out 1 sticky timeout flag

Function
REQ-008 SHALL decode opcodes: 0x01 READ, 0x02 WRITE, 0x03 BREAD, 0x04 BWRITE, 0x10 CLR_ERR, 0xFE RST_A, 0xFF RST_D; any other opcode completes with no bus activity.
REQ-009 SHALL implement states IDLE, WDATA, REQ, RESP, RDOUT, DONE.
REQ-010 SHALL drive cmd_ready=1 only in IDLE; a command is accepted on cmd_valid&&cmd_ready, latching op, addr, len.
REQ-011 SHALL force beat count to 1 for READ/WRITE (cmd_len ignored) and to cmd_len+1 for BREAD/BWRITE.
REQ-012 SHALL, for RST_A/RST_D, set rst_n_out to 0/1 and for CLR_ERR clear err_timeout, each on the acceptance cycle, then go to DONE.
REQ-013 SHALL, on write ops, enter WDATA with wr_ready=1; on wr_valid the beat is latched into wdata and the state moves to REQ.
REQ-014 SHALL, in REQ, hold wvalid (write) or rvalid (read) high with address/wdata stable until ready; the request is accepted in the cycle both are high.
REQ-015 SHALL, on write acceptance, count the beat; if beats remain, increment address by ADDR_INC modulo 2^ADDR_WIDTH and return to WDATA, else go to DONE.
REQ-016 SHALL, on read acceptance, enter RESP; rsp_valid captures rsp_data into rd_data and moves to RDOUT; rsp_valid outside RESP is ignored.
REQ-017 SHALL, in RDOUT, hold rd_valid=1 until rd_ready; then, like REQ-015, increment address and return to REQ or go to DONE.
REQ-018 SHALL spend exactly one cycle in DONE with done=1, then return to IDLE.
REQ-019 SHALL count cycles in REQ and RESP per beat, restarting at each beat; on reaching TIMEOUT, deassert wvalid/rvalid, set err_timeout, abort remaining beats and go to DONE.
REQ-020 SHALL not time out in WDATA or RDOUT (host-side stalls are unbounded).
REQ-021 SHALL give CLR_ERR priority over no simultaneous set (a timeout cannot occur in the CLR_ERR cycle).

Reset
REQ-022 SHALL, on rst_n low at any time including mid-burst, go to IDLE immediately with wvalid=rvalid=rd_valid=wr_ready=done=busy=err_timeout=0, address=wdata=rd_data=0, rst_n_out=1, cmd_ready=1 after release.

Verification
REQ-023 WRITE addr 0x0010, wr_data 0xBEEF, ready high -> one wvalid cycle with address 0x0010 wdata 0xBEEF, done pulse, busy low next cycle.
REQ-024 BREAD addr 0xFFFE len 2, rsp_data 0xA,0xB,0xC -> addresses 0xFFFE,0xFFFF,0x0000, rd_data 0xA,0xB,0xC in order with rd_ready stalls honoured.
REQ-025 READ with ready held low -> rvalid high for 255 cycles then low, err_timeout=1, done pulse; CLR_ERR then clears err_timeout.
REQ-026 BWRITE len 3 with wr_valid gaps and ready toggling -> exactly 4 wvalid&&ready handshakes, addresses base..base+3, no wvalid while in WDATA.
REQ-027 RST_A then RST_D -> rst_n_out 0 then 1, no bus activity; opcode 0x55 -> done pulse only.
REQ-028 rst_n asserted mid-BREAD (in RESP) -> all outputs return to reset values asynchronously; following READ runs normally.
